// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: N-master to 1-slave Wishbone classic arbiter (RR or fixed priority) with timeout watchdog.
// Latency: m_cyc seen at edge k on an idle bus -> grant/s_cyc from cycle k+1; s_* is a comb mux on registered grant.
// Backpressure: owner keeps the bus while it holds m_cyc; other requesters wait, timed-out owners stay masked until they drop cyc.
//
// Ports: clk/rst_n; per-master m_cyc/m_stb/m_we/m_addr/m_dat_w/m_sel in, m_dat_r/m_ack/m_err out;
//        slave s_cyc/s_stb/s_we/s_addr/s_dat_w/s_sel out, s_dat_r/s_ack in; grant (one-hot owner), err_cnt.
module wb_master_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_cyc,
    input  logic [N_MASTERS-1:0]          m_stb,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_dat_w,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_sel,
    output logic [DATA_W-1:0]             m_dat_r,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_dat_w,
    output logic [DATA_W/8-1:0]           s_sel,
    input  logic [DATA_W-1:0]             s_dat_r,
    input  logic                          s_ack,
    output logic [N_MASTERS-1:0]          grant,
    output logic [7:0]                    err_cnt
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    // Watchdog fires during the TIMEOUT-th consecutive unacked strobe cycle,
    // i.e. when the count of earlier such cycles equals TIMEOUT-1.
    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;     // binary form of grant, valid while OWNED
    logic [IDX_W-1:0]     rr_ptr;    // first index searched at next arbitration
    logic [N_MASTERS-1:0] mask;      // masters locked out after a timeout
    logic [31:0]          wd_cnt;

    logic                 owned;
    logic                 owner_cyc;
    logic                 owner_stb;
    logic                 wd_hit;
    logic [N_MASTERS-1:0] cand;
    logic [IDX_W-1:0]     start;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [N_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]     win_next_ptr;

    assign owned     = (state == OWNED);
    assign owner_cyc = m_cyc[owner];
    assign owner_stb = m_stb[owner];
    assign wd_hit    = (TIMEOUT > 0) && owned && owner_stb && !s_ack && (wd_cnt == WD_LAST);

    // Slave side: mux of the registered owner; the abort cycle withholds cyc/stb.
    assign s_cyc   = owned && owner_cyc && !wd_hit;
    assign s_stb   = owned && owner_stb && !wd_hit;
    assign s_we    = owned && m_we[owner];
    assign s_addr  = owned ? m_addr[int'(owner)*ADDR_W +: ADDR_W] : '0;
    assign s_dat_w = owned ? m_dat_w[int'(owner)*DATA_W +: DATA_W] : '0;
    assign s_sel   = owned ? m_sel[int'(owner)*SEL_W +: SEL_W] : '0;

    assign m_dat_r = s_dat_r;
    assign m_ack   = (s_ack && owned) ? grant : '0;
    assign m_err   = wd_hit ? grant : '0;

    // Candidates: live, unmasked requests; the current owner is excluded when
    // re-arbitrating at the end of its tenure.
    assign cand  = m_cyc & ~mask & (owned ? ~grant : {N_MASTERS{1'b1}});
    assign start = (RR_MODE != 0) ? rr_ptr : '0;

    // Walk search order backwards so the earliest candidate after start wins.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (cand[idx[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = idx[IDX_W-1:0];
            end
        end
    end

    assign win_onehot   = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
    assign win_next_ptr = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            rr_ptr  <= '0;
            mask    <= '0;
            wd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            mask <= (mask & m_cyc) | (wd_hit ? grant : '0);
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (win_vld) begin
                        state  <= OWNED;
                        grant  <= win_onehot;
                        owner  <= win_idx;
                        rr_ptr <= win_next_ptr;
                    end
                end
                OWNED: begin
                    if (wd_hit) begin
                        state  <= IDLE;
                        grant  <= '0;
                        wd_cnt <= '0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else if (!owner_cyc) begin
                        wd_cnt <= '0;
                        if (win_vld) begin
                            grant  <= win_onehot;
                            owner  <= win_idx;
                            rr_ptr <= win_next_ptr;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (s_ack) begin
                        wd_cnt <= '0;
                    end else if (owner_stb) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
